sap1_sequencer: RTL and testbench
=================================

# sap1_sequencer

Run/step/halt controller-sequencer for the SAP-1 processor. It generates the T-state ring and drives the 12-bit control word onto `cntrl_bus` for every datapath register (PC, MAR, RAM, IR, A, ALU, B, OUT).
- Free-run and single-step modes; stepping never double-fires edge-sensitive loads.
- Optional early termination of short instructions.
- Latched halt on HLT.

It sits between the instruction register's opcode field and the datapath control inputs.

## Interface
- `EARLY_END`, default 1: when 1, LDA ends after T5, and OUT/undefined opcodes end after T4. When 0, every instruction uses T1–T6.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, asynchronous and active-high.
- `opcode`  in  4  IR upper nibble; valid from T4 onward.
- `run`  in  1  1 = free-run (advance every cycle); 0 = step mode.
- `step`  in  1  step request level; only its rising edge counts.
- `cntrl_bus`  out  12  control word, bits 11..0 = Cp Ep ~Lm ~CE ~Li ~Ei ~La Ea Su Eu ~Lb ~Lo.
- `tstate`  out  6  one-hot T-state, bit0 = T1 … bit5 = T6.
- `halted`  out  1  HLT executed; sticky until `clr`.
- `step_ack`  out  1  one-cycle pulse after a step-mode advance.

## Operation
- Advance condition: `adv = !halted & (run | (step & !step_d))`, where `step_d` is `step` registered.
- `cntrl_bus` is combinational: it equals word(T, op) when `adv` is high, else NOP 12'h3E3. While `clr` is high it is forced to 3E3.
- Fetch words:
  - T1 = 5E3 (Ep, ~Lm)
  - T2 = BE3 (Cp)
  - T3 = 263 (~CE, ~Li)
- LDA 0000:
  - T4 = 1A3 (~Lm, ~Ei)
  - T5 = 2C3 (~CE, ~La)
  - T6 = 3E3
- ADD 0001:
  - T4 = 1A3
  - T5 = 2E1 (~CE, ~Lb)
  - T6 = 3C7 (~La, Eu)
- SUB 0010: same as ADD, but T6 = 3CF (~La, Su, Eu).
- OUT 1110: T4 = 3F2 (Ea, ~Lo); T5 = T6 = 3E3.
- HLT 1111: T4 = 3E3; on the T4 advance edge, `halted` is set to 1.
- Undefined opcodes: T4–T6 = 3E3.
- Opcode sourcing: T4 decodes the live `opcode`. On the T4 advance edge `op_q <= opcode`, and T5/T6 decode `op_q`.
- T-state sequencing on an advance edge:
  - T(n) → T(n+1).
  - T6 → T1.
  - Early-end states (per `EARLY_END`) → T1.
  - No advance → hold.
- Halted:
  - `tstate` holds T4 and `cntrl_bus` = 3E3.
  - `run` and `step` are ignored, and `step_ack` stays 0.
  - Only `clr` exits this state.
- `step_ack` is registered: `step_ack <= adv & !run`.

## Timing
- Reset values while `clr` is high:
  - `tstate` = 6'b000001
  - `halted` = 0
  - `step_ack` = 0
  - `op_q` = 0
  - `step_d` = 0
  - `cntrl_bus` = 3E3
- First word after `clr` falls: T1, driven in the same cycle if `adv`.
- Latency:
  - control word: 0 cycles from T-state/opcode.
  - `step_ack`: 1 cycle after the advance.
  - `halted`: rises at the edge ending HLT T4.
- Step held high: exactly one advance. A new rising edge is required for the next.
- Step rising edge while `run`=1: behaves as a normal advance; `step_ack` stays 0.
- `run` toggled mid-instruction: sequencing continues from the current T-state; no state is lost.
- `clr` asserted mid-instruction (any T): immediate return to reset values, no partial word. Takes priority over HLT in the same cycle.
- Cycles per instruction, `run`=1:
  - `EARLY_END`=1: LDA 5, ADD/SUB 6, OUT 4, undefined 4.
  - `EARLY_END`=0: all 6.

## Structure
- Shared package `sap1_pkg`:
  - opcode constants (LDA/ADD/SUB/OUT/HLT)
  - control-word bit indices
  - named words `CW_NOP`=3E3, `CW_T1`, `CW_T2`, `CW_T3`, etc.
  - T-state one-hot constants
- Sub-module `sap1_cw_rom`: purely combinational (tstate, opcode) → 12-bit word. The top level owns the ring, `op_q`, step edge detect, halt and `adv` gating.

## Test plan
- `clr` pulse, `run`=1, `opcode`=0000, `EARLY_END`=1 → `cntrl_bus` 5E3, BE3, 263, 1A3, 2C3, then 5E3; `tstate` 01, 02, 04, 08, 10, 01.
- `opcode`=0001 then 0010, `run`=1 → T4–T6 = 1A3, 2E1, 3C7 (ADD) and 1A3, 2E1, 3CF (SUB); 6 cycles each.
- `opcode`=1110 → T4 = 3F2, then T1. With `EARLY_END`=0: T5 = T6 = 3E3, and T1 follows T6.
- `opcode`=1111, `run`=1 → T4 word 3E3; `halted`=1 next cycle; `tstate` stays 08 and `cntrl_bus` stays 3E3 for 20 cycles despite `run` and `step`. `clr` → `halted`=0, `tstate`=01.
- `run`=0, `step` held high 5 cycles from T1 → 5E3 for one cycle only, then 3E3; `tstate` 01→02 once; `step_ack`=1 for exactly one cycle; a second `step` edge gives BE3.
- `clr` asserted asynchronously mid-T5 of ADD → `tstate`=01, `cntrl_bus`=3E3, `halted`=0 immediately. After release, `cntrl_bus`=5E3.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 sequencer: opcodes, control-word bit positions,
// named control words and the one-hot T-state encoding.
package sap1_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Bit positions in cntrl_bus; _N marks active-low strobes
   localparam int CW_CP   = 11;
   localparam int CW_EP   = 10;
   localparam int CW_LM_N = 9;
   localparam int CW_CE_N = 8;
   localparam int CW_LI_N = 7;
   localparam int CW_EI_N = 6;
   localparam int CW_LA_N = 5;
   localparam int CW_EA   = 4;
   localparam int CW_SU   = 3;
   localparam int CW_EU   = 2;
   localparam int CW_LB_N = 1;
   localparam int CW_LO_N = 0;

   localparam logic [11:0] CW_NOP    = 12'h3E3;
   localparam logic [11:0] CW_T1     = 12'h5E3;  // Ep, ~Lm
   localparam logic [11:0] CW_T2     = 12'hBE3;  // Cp
   localparam logic [11:0] CW_T3     = 12'h263;  // ~CE, ~Li
   localparam logic [11:0] CW_MAR_IR = 12'h1A3;  // ~Lm, ~Ei
   localparam logic [11:0] CW_LDA_T5 = 12'h2C3;  // ~CE, ~La
   localparam logic [11:0] CW_ALU_T5 = 12'h2E1;  // ~CE, ~Lb
   localparam logic [11:0] CW_ADD_T6 = 12'h3C7;  // ~La, Eu
   localparam logic [11:0] CW_SUB_T6 = 12'h3CF;  // ~La, Su, Eu
   localparam logic [11:0] CW_OUT_T4 = 12'h3F2;  // Ea, ~Lo

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } tstate_e;

endpackage

// File: rtl/sap1_sequencer_if.sv
// Opcode/run/step inputs and control-word/status outputs of the sequencer.
interface sap1_sequencer_if;
   logic [3:0]  opcode;
   logic        run;
   logic        step;
   logic [11:0] cntrl_bus;
   logic [5:0]  tstate;
   logic        halted;
   logic        step_ack;

   modport master (output opcode, run, step,
                   input  cntrl_bus, tstate, halted, step_ack);
   modport slave  (input  opcode, run, step,
                   output cntrl_bus, tstate, halted, step_ack);
endinterface

// File: rtl/sap1_cw_rom.sv
// Combinational control-word table: (T-state, opcode) -> 12-bit control word.
module sap1_cw_rom
   import sap1_pkg::*;
(
   input  tstate_e     tstate,
   input  logic [3:0]  opcode,
   output logic [11:0] word
);

   always_comb begin
      word = CW_NOP;
      case (tstate)
         T1: word = CW_T1;
         T2: word = CW_T2;
         T3: word = CW_T3;
         T4: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB: word = CW_MAR_IR;
               OP_OUT:                 word = CW_OUT_T4;
               default:                word = CW_NOP;
            endcase
         end
         T5: begin
            case (opcode)
               OP_LDA:         word = CW_LDA_T5;
               OP_ADD, OP_SUB: word = CW_ALU_T5;
               default:        word = CW_NOP;
            endcase
         end
         T6: begin
            case (opcode)
               OP_ADD:  word = CW_ADD_T6;
               OP_SUB:  word = CW_SUB_T6;
               default: word = CW_NOP;
            endcase
         end
         default: word = CW_NOP;
      endcase
   end

endmodule

// File: rtl/sap1_sequencer.sv
// SAP-1 run/step/halt sequencer: T-state ring, opcode latch, step edge detect
// and halt latch; the control word is gated by the advance condition.
module sap1_sequencer
   import sap1_pkg::*;
#(
   parameter bit EARLY_END = 1'b1
) (
   input logic             clk,
   input logic             clr,
   sap1_sequencer_if.slave sq
);

   tstate_e     state, state_nxt;
   logic [3:0]  op_q, op_sel;
   logic        step_d, halted_q, step_ack_q;
   logic        adv, halt_hit, end_now;
   logic [11:0] rom_word;

   // T4 decodes the live opcode; later states use the copy latched at T4
   assign op_sel = (state == T4) ? sq.opcode : op_q;
   assign adv    = !halted_q && (sq.run || (sq.step && !step_d));

   sap1_cw_rom u_rom (
      .tstate (state),
      .opcode (op_sel),
      .word   (rom_word)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= T1;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      halt_hit  = 1'b0;
      end_now   = 1'b0;
      if (EARLY_END) begin
         case (state)
            T4:      end_now = !(op_sel inside {OP_LDA, OP_ADD, OP_SUB});
            T5:      end_now = (op_sel == OP_LDA);
            default: end_now = 1'b0;
         endcase
      end
      if (adv) begin
         case (state)
            T1: state_nxt = T2;
            T2: state_nxt = T3;
            T3: state_nxt = T4;
            T4: begin
               // HLT parks the ring on T4 so the halted display reads T4
               halt_hit  = (op_sel == OP_HLT);
               state_nxt = halt_hit ? T4 : (end_now ? T1 : T5);
            end
            T5:      state_nxt = end_now ? T1 : T6;
            default: state_nxt = T1;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         op_q       <= 4'h0;
         step_d     <= 1'b0;
         halted_q   <= 1'b0;
         step_ack_q <= 1'b0;
      end else begin
         step_d     <= sq.step;
         step_ack_q <= adv && !sq.run;
         if (adv && state == T4) op_q <= sq.opcode;
         if (halt_hit)            halted_q <= 1'b1;
      end
   end

   assign sq.cntrl_bus = (clr || !adv) ? CW_NOP : rom_word;
   assign sq.tstate    = state;
   assign sq.halted    = halted_q;
   assign sq.step_ack  = step_ack_q;

endmodule

// File: tb/tb_sap1_sequencer.sv
// Bench for sap1_sequencer: two instances (EARLY_END=1 and 0) share stimulus and
// are compared every cycle against an instruction-level model plus literal sequences.
module tb_sap1_sequencer;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       run = 1'b0;
   logic       step = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic       cmp_en = 1'b0;
   int         n_chk = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   sap1_sequencer_if if_e1 ();
   sap1_sequencer_if if_e0 ();
   assign if_e1.opcode = opcode;
   assign if_e1.run    = run;
   assign if_e1.step   = step;
   assign if_e0.opcode = opcode;
   assign if_e0.run    = run;
   assign if_e0.step   = step;

   sap1_sequencer #(.EARLY_END(1'b1)) dut_e1 (.clk(clk), .clr(clr), .sq(if_e1));
   sap1_sequencer #(.EARLY_END(1'b0)) dut_e0 (.clk(clk), .clr(clr), .sq(if_e0));

   // Model state, index k = EARLY_END setting; mt is the T number 1..6
   int         mt [2];
   logic [3:0] mop [2];
   logic       mh [2];
   logic       mack [2];
   logic       m_stepd;
   logic       m_adv;
   logic [3:0] m_op;

   // Control word straight from the instruction table
   function automatic logic [11:0] cw(input int t, input logic [3:0] op);
      case (t)
         1: return 12'h5E3;
         2: return 12'hBE3;
         3: return 12'h263;
         4: return (op <= 4'h2) ? 12'h1A3 : (op == 4'hE) ? 12'h3F2 : 12'h3E3;
         5: return (op == 4'h0) ? 12'h2C3 : (op == 4'h1 || op == 4'h2) ? 12'h2E1 : 12'h3E3;
         6: return (op == 4'h1) ? 12'h3C7 : (op == 4'h2) ? 12'h3CF : 12'h3E3;
         default: return 12'h3E3;
      endcase
   endfunction

   // Number of T-states an instruction occupies
   function automatic int ilen(input logic [3:0] op, input int ee);
      if (ee == 0) return 6;
      if (op == 4'h0) return 5;
      if (op == 4'h1 || op == 4'h2) return 6;
      return 4;
   endfunction

   always @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int k = 0; k < 2; k++) begin
            mt[k] <= 1; mop[k] <= 4'h0; mh[k] <= 1'b0; mack[k] <= 1'b0;
         end
         m_stepd <= 1'b0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_adv = !mh[k] && (run || (step && !m_stepd));
            m_op  = (mt[k] == 4) ? opcode : mop[k];
            mack[k] <= m_adv && !run;
            if (m_adv) begin
               if (mt[k] == 4) mop[k] <= opcode;
               if (mt[k] == 4 && opcode == 4'hF) mh[k] <= 1'b1;
               else if (mt[k] >= ilen(m_op, k))  mt[k] <= 1;
               else                              mt[k] <= mt[k] + 1;
            end
         end
         m_stepd <= step;
      end
   end

   function automatic logic [11:0] exp_bus(input int k);
      logic a;
      a = !mh[k] && (run || (step && !m_stepd));
      if (clr || !a) return 12'h3E3;
      return cw(mt[k], (mt[k] == 4) ? opcode : mop[k]);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic cmp(input int k, input logic [11:0] b, input logic [5:0] ts,
                      input logic h, input logic a);
      logic [5:0] ets;
      ets = 6'b1 << (mt[k] - 1);
      chk($sformatf("model_bus_ee%0d", k), 16'(b), 16'(exp_bus(k)));
      chk($sformatf("model_tstate_ee%0d", k), 16'(ts), 16'(ets));
      chk($sformatf("model_halted_ee%0d", k), 16'(h), 16'(mh[k]));
      chk($sformatf("model_step_ack_ee%0d", k), 16'(a), 16'(mack[k]));
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp(1, if_e1.cntrl_bus, if_e1.tstate, if_e1.halted, if_e1.step_ack);
         cmp(0, if_e0.cntrl_bus, if_e0.tstate, if_e0.halted, if_e0.step_ack);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [3:0] op, input logic r);
      clr = 1'b1; step = 1'b0;
      tick(); tick();
      opcode = op; run = r; clr = 1'b0;
   endtask

   logic [11:0] lda_b [6] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h5E3};
   logic [5:0]  lda_t [6] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h01};
   logic [11:0] add_b [6] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3C7};
   logic [11:0] out1_b [7] = '{12'h5E3, 12'hBE3, 12'h263, 12'h3F2, 12'h5E3, 12'hBE3, 12'h263};
   logic [11:0] out0_b [7] = '{12'h5E3, 12'hBE3, 12'h263, 12'h3F2, 12'h3E3, 12'h3E3, 12'h5E3};

   initial begin
      tick();
      cmp_en = 1'b1;
      @(negedge clk);
      chk("reset_bus", 16'(if_e1.cntrl_bus), 16'h3E3);
      chk("reset_tstate", 16'(if_e1.tstate), 16'h01);
      chk("reset_halted", 16'(if_e1.halted), 16'h0);
      chk("reset_step_ack", 16'(if_e1.step_ack), 16'h0);

      do_reset(4'h0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("lda_bus_%0d", i), 16'(if_e1.cntrl_bus), 16'(lda_b[i]));
         chk($sformatf("lda_tstate_%0d", i), 16'(if_e1.tstate), 16'(lda_t[i]));
         tick();
      end

      do_reset(4'h1, 1'b1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk($sformatf("addsub_bus_%0d", i), 16'(if_e1.cntrl_bus),
             16'((i == 11) ? 12'h3CF : add_b[i % 6]));
         tick();
         if (i == 5) opcode = 4'h2;
      end

      do_reset(4'hE, 1'b1);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk($sformatf("out_ee1_bus_%0d", i), 16'(if_e1.cntrl_bus), 16'(out1_b[i]));
         chk($sformatf("out_ee0_bus_%0d", i), 16'(if_e0.cntrl_bus), 16'(out0_b[i]));
         tick();
      end

      do_reset(4'hF, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 3) begin
            chk("hlt_t4_bus", 16'(if_e1.cntrl_bus), 16'h3E3);
            chk("hlt_t4_halted", 16'(if_e1.halted), 16'h0);
         end
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         run = 1'($urandom); step = 1'($urandom);
         @(negedge clk);
         chk("halt_tstate", 16'(if_e1.tstate), 16'h08);
         chk("halt_bus", 16'(if_e1.cntrl_bus), 16'h3E3);
         chk("halt_halted", 16'(if_e1.halted), 16'h1);
         chk("halt_step_ack", 16'(if_e1.step_ack), 16'h0);
         tick();
      end
      clr = 1'b1;
      #1;
      chk("halt_clr_halted", 16'(if_e1.halted), 16'h0);
      chk("halt_clr_tstate", 16'(if_e1.tstate), 16'h01);

      do_reset(4'h0, 1'b0);
      step = 1'b1;
      @(negedge clk);
      chk("step_first_bus", 16'(if_e1.cntrl_bus), 16'h5E3);
      chk("step_first_ack", 16'(if_e1.step_ack), 16'h0);
      tick();
      @(negedge clk);
      chk("step_held_bus", 16'(if_e1.cntrl_bus), 16'h3E3);
      chk("step_held_tstate", 16'(if_e1.tstate), 16'h02);
      chk("step_ack_pulse", 16'(if_e1.step_ack), 16'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("step_held_bus2", 16'(if_e1.cntrl_bus), 16'h3E3);
         chk("step_held_tstate2", 16'(if_e1.tstate), 16'h02);
         chk("step_ack_low", 16'(if_e1.step_ack), 16'h0);
      end
      tick();
      step = 1'b0;
      tick();
      step = 1'b1;
      @(negedge clk);
      chk("step_second_bus", 16'(if_e1.cntrl_bus), 16'hBE3);

      do_reset(4'h1, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      #1;
      chk("clr_mid_t5_bus_before", 16'(if_e1.cntrl_bus), 16'h2E1);
      clr = 1'b1;
      #1;
      chk("clr_mid_tstate", 16'(if_e1.tstate), 16'h01);
      chk("clr_mid_bus", 16'(if_e1.cntrl_bus), 16'h3E3);
      chk("clr_mid_halted", 16'(if_e1.halted), 16'h0);
      tick();
      clr = 1'b0;
      @(negedge clk);
      chk("clr_release_bus", 16'(if_e1.cntrl_bus), 16'h5E3);

      // Random mix of run/step, opcodes biased to defined ones, occasional clr
      for (int i = 0; i < 3000; i++) begin
         tick();
         run  = ($urandom_range(0, 2) == 0);
         step = 1'($urandom);
         case ($urandom_range(0, 7))
            0, 1:    opcode = 4'h0;
            2:       opcode = 4'h1;
            3:       opcode = 4'h2;
            4:       opcode = 4'hE;
            5:       opcode = 4'hF;
            default: opcode = 4'($urandom);
         endcase
         clr = ($urandom_range(0, 59) == 0);
      end
      tick();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
